tt_stim_capture: RTL and testbench

- Synthesisable, parametrised stimulus-generator and response-compactor harness that sits between the TinyTapeout pin wrapper and a user project core.
- Drives the core's dedicated inputs with an LFSR or counting pattern for a programmed number of cycles.
- Compacts the core's outputs into a MISR signature, so designs self-test on silicon without an external bench.
- Successor to the passive pin-wiring wrapper: adds width, mode, run-length control and signature capture.

---
 rtl/tt_harness_pkg.sv | 18 +
 rtl/galois_step.sv | 15 +
 rtl/tt_stim_capture.sv | 130 +++++++++++++
 tb/tb_tt_stim_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tt_harness_pkg.sv
// Shared types and default constants for the stimulus/capture harness.
package tt_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_LFSR  = 1'b0;
    localparam logic MODE_COUNT = 1'b1;

    // x^8+x^6+x^5+x^4+1 in Galois right-shift form
    localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
    localparam logic [7:0] DEF_MISR_TAPS = 8'hB8;
    localparam logic [7:0] DEF_SEED      = 8'h01;

endpackage

// File: rtl/galois_step.sv
// One combinational step of a Galois right-shift register.
// With data_in tied to zero this is a plain LFSR step; with data_in
// driven by a response bus it is one MISR compaction step.
module galois_step #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = '0
) (
    input  logic [WIDTH-1:0] state_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] state_out
);

    assign state_out = (state_in >> 1) ^ (state_in[0] ? TAPS : '0) ^ data_in;

endmodule

// File: rtl/tt_stim_capture.sv
// Self-test harness: drives an LFSR or counting stimulus for a programmed
// number of cycles and compacts the core response into a MISR signature.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, waiting for start
// RUN     | stimulus advancing, response compacted every enabled cycle
// DONE    | run finished, results held until the next start
module tt_stim_capture
    import tt_harness_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
    parameter logic [WIDTH-1:0] MISR_TAPS = DEF_MISR_TAPS,
    parameter logic [WIDTH-1:0] SEED      = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic [WIDTH-1:0] resp_in,
    output logic [WIDTH-1:0] stim_out,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH-1:0] stim_d, sig_d;
    logic [CNT_W-1:0] cnt_d;

    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] misr_next;
    logic [CNT_W-1:0] cnt_inc;

    galois_step #(
        .WIDTH (WIDTH),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr_step (
        .state_in  (stim_out),
        .data_in   ('0),
        .state_out (lfsr_next)
    );

    galois_step #(
        .WIDTH (WIDTH),
        .TAPS  (MISR_TAPS)
    ) u_misr_step (
        .state_in  (signature),
        .data_in   (resp_in),
        .state_out (misr_next)
    );

    assign cnt_inc = cycle_cnt + CNT_W'(1);

    // Next-state and next-register logic; everything holds unless ena=1.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        stim_d  = stim_out;
        sig_d   = signature;
        cnt_d   = cycle_cnt;

        if (ena) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_d  = mode;
                        len_d   = num_cycles;
                        sig_d   = '0;
                        cnt_d   = '0;
                        stim_d  = (mode == MODE_LFSR) ? SEED : '0;
                        // A zero-length run still passes through DONE so
                        // software sees a completed, empty signature.
                        state_d = (num_cycles == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    sig_d  = misr_next;
                    stim_d = (mode_q == MODE_LFSR) ? lfsr_next
                                                   : stim_out + WIDTH'(1);
                    cnt_d  = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched run settings, stimulus, signature, count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_LFSR;
            len_q     <= '0;
            stim_out  <= '0;
            signature <= '0;
            cycle_cnt <= '0;
        end else begin
            mode_q    <= mode_d;
            len_q     <= len_d;
            stim_out  <= stim_d;
            signature <= sig_d;
            cycle_cnt <= cnt_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_tt_stim_capture.sv
// Directed bench for tt_stim_capture: a table of complete runs with
// hand-computed results plus hand-written multi-cycle corner cases.
module tb_tt_stim_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        start;
    logic        mode;
    logic [15:0] num_cycles;
    logic [7:0]  resp_in;
    logic [7:0]  stim_out;
    logic [7:0]  signature;
    logic [15:0] cycle_cnt;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    tt_stim_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .mode       (mode),
        .num_cycles (num_cycles),
        .resp_in    (resp_in),
        .stim_out   (stim_out),
        .signature  (signature),
        .cycle_cnt  (cycle_cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        m;
        logic [15:0] n;
        logic [7:0]  r;
        logic [7:0]  sig;
        logic [7:0]  stim;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then run until busy drops (bounded), checking per-cycle
    // stimulus against seq (if nseq>0) or against the binary count (mode 1).
    task automatic run(input string nm, input logic m, input logic [15:0] n,
                       input logic [7:0] r, input logic [7:0] exp_sig,
                       input logic [7:0] exp_stim, input logic [15:0] exp_cnt,
                       input logic [7:0] seq[8], input int nseq);
        int bc;
        logic [31:0] idx;
        mode = m; num_cycles = n; resp_in = r; start = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, " done_clr"}, {31'd0, done}, {31'd0, (n == 16'd0)});
        bc = 0;
        while (busy && bc < 2000) begin
            idx = bc;
            if (bc < nseq) chk({nm, " stim_seq"}, {24'd0, stim_out}, {24'd0, seq[bc]});
            else if (m && nseq == 0) chk({nm, " stim_cnt"}, {24'd0, stim_out}, {24'd0, idx[7:0]});
            bc++;
            tick();
        end
        chk({nm, " busy_len"}, bc, {16'd0, n});
        chk({nm, " done"}, {31'd0, done}, 32'd1);
        chk({nm, " sig"}, {24'd0, signature}, {24'd0, exp_sig});
        chk({nm, " stim_end"}, {24'd0, stim_out}, {24'd0, exp_stim});
        chk({nm, " cnt"}, {16'd0, cycle_cnt}, {16'd0, exp_cnt});
    endtask

    logic [7:0] noseq[8];
    logic [7:0] seq_cnt[8];
    logic [7:0] seq_lfsr[8];

    initial begin
        int bc;
        noseq    = '{default: 8'h00};
        seq_cnt  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
        seq_lfsr = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'h00, 8'h00};

        //          name       m     n        r      sig    stim   cnt
        tbl[0] = '{"cnt4",    1'b1, 16'd4,   8'h00, 8'h00, 8'h04, 16'd4};
        tbl[1] = '{"lfsr5",   1'b0, 16'd5,   8'h00, 8'h00, 8'hB3, 16'd5};
        tbl[2] = '{"misr2",   1'b1, 16'd2,   8'h01, 8'hB9, 8'h02, 16'd2};
        tbl[3] = '{"zero",    1'b0, 16'd0,   8'h55, 8'h00, 8'h01, 16'd0};
        tbl[4] = '{"wrap257", 1'b1, 16'd257, 8'h00, 8'h00, 8'h01, 16'd257};
        tbl[5] = '{"misr1",   1'b1, 16'd1,   8'h5A, 8'h5A, 8'h01, 16'd1};
        tbl[6] = '{"misr3",   1'b1, 16'd3,   8'hFF, 8'hE3, 8'h03, 16'd3};

        rst_n = 1'b0; ena = 1'b1; start = 1'b0; mode = 1'b0;
        num_cycles = '0; resp_in = '0;
        #12;
        chk("rst stim", {24'd0, stim_out}, 32'd0);
        chk("rst sig", {24'd0, signature}, 32'd0);
        chk("rst cnt", {16'd0, cycle_cnt}, 32'd0);
        chk("rst busy_done", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run(tbl[i].name, tbl[i].m, tbl[i].n, tbl[i].r, tbl[i].sig,
                tbl[i].stim, tbl[i].cnt, noseq, 0);
        end

        // Explicit stimulus sequences.
        run("seq_cnt4", 1'b1, 16'd4, 8'h00, 8'h00, 8'h04, 16'd4, seq_cnt, 4);
        run("seq_lfsr6", 1'b0, 16'd6, 8'h00, 8'h00, 8'hE1, 16'd6, seq_lfsr, 6);

        // Pause: 3 ena=0 cycles in the middle of a 4-cycle run.
        mode = 1'b1; num_cycles = 16'd4; resp_in = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        bc = 0;
        tick(); bc++;
        tick(); bc++;
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("pause stim_hold", {24'd0, stim_out}, 32'h02);
            chk("pause busy", {31'd0, busy}, 32'd1);
            tick(); bc++;
        end
        ena = 1'b1;
        while (busy && bc < 100) begin
            tick(); bc++;
        end
        chk("pause busy_len", bc, 32'd7);
        chk("pause sig", {24'd0, signature}, 32'hCB);
        chk("pause stim", {24'd0, stim_out}, 32'h04);
        chk("pause cnt", {16'd0, cycle_cnt}, 32'd4);

        // Start during RUN must not disturb the latched mode or length.
        mode = 1'b1; num_cycles = 16'd4; resp_in = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        bc = 1;
        tick();
        mode = 1'b0; num_cycles = 16'd9; start = 1'b1;
        tick(); bc++;
        start = 1'b0;
        while (busy && bc < 100) begin
            tick(); bc++;
        end
        chk("ign_start busy_len", bc, 32'd4);
        chk("ign_start stim", {24'd0, stim_out}, 32'h04);
        chk("ign_start cnt", {16'd0, cycle_cnt}, 32'd4);

        // Start in DONE restarts cleanly.
        mode = 1'b1; num_cycles = 16'd2; resp_in = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart done", {31'd0, done}, 32'd0);
        chk("restart busy", {31'd0, busy}, 32'd1);
        chk("restart cnt", {16'd0, cycle_cnt}, 32'd0);
        chk("restart stim", {24'd0, stim_out}, 32'd0);

        // Asynchronous reset mid-run, mid-clock.
        resp_in = 8'h3C;
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst stim", {24'd0, stim_out}, 32'd0);
        chk("async_rst sig", {24'd0, signature}, 32'd0);
        chk("async_rst cnt", {16'd0, cycle_cnt}, 32'd0);
        chk("async_rst busy_done", {30'd0, busy, done}, 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        chk("post_rst idle", {30'd0, busy, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
